// File: rtl/axi_lite_spi_slave.sv
// SPI mode-0 slave (8-bit, MSB first) with an AXI4-Lite register file.
// SPI pins are oversampled and edge-detected in the clk domain.
module axi_lite_spi_slave #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        spi_clk,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   input  logic [31:0] axi_lite_araddr,
   input  logic        axi_lite_arvalid,
   output logic        axi_lite_arready,
   output logic [31:0] axi_lite_rdata,
   output logic        axi_lite_rvalid,
   input  logic        axi_lite_rready,
   input  logic [31:0] axi_lite_awaddr,
   input  logic        axi_lite_awvalid,
   output logic        axi_lite_awready,
   input  logic [31:0] axi_lite_wdata,
   input  logic [3:0]  axi_lite_wstrb,
   input  logic        axi_lite_wvalid,
   output logic        axi_lite_wready,
   output logic [1:0]  axi_lite_bresp,
   output logic        axi_lite_bvalid,
   input  logic        axi_lite_bready
);

   localparam logic [3:0] ADDR_RX = 4'h0;
   localparam logic [3:0] ADDR_TX = 4'h4;
   localparam logic [3:0] ADDR_ST = 4'h8;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic sclk_d;
   logic cs_d;

   // Not reset: the chains keep tracking the pins during reset so that
   // a CS already low at release does not look like a fresh falling edge.
   always_ff @(posedge clk) begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
   end

   logic sclk_s;
   logic cs_s;
   logic mosi_s;
   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   logic cs_act;
   logic cs_fall;
   logic cs_rise;
   logic sclk_rise;
   logic sclk_fall;
   assign cs_act    = ~cs_s;
   assign cs_fall   = cs_d & ~cs_s;
   assign cs_rise   = ~cs_d & cs_s;
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;

   logic [6:0] rx_shift;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       overrun;
   logic [7:0] tx_shift;
   logic [7:0] tx_buf;
   logic       tx_full;
   logic [2:0] bit_cnt;
   logic       miso;

   logic [7:0] load_byte;
   logic [7:0] rx_byte;
   assign load_byte = tx_full ? tx_buf : 8'h00;
   assign rx_byte   = {rx_shift, mosi_s};

   logic [3:0] status;
   assign status = {overrun, tx_full, rx_valid, cs_act};

   logic wr_go;
   logic rd_go;
   assign wr_go = resetn & axi_lite_awvalid & axi_lite_wvalid
                & ~axi_lite_bvalid;
   assign rd_go = resetn & axi_lite_arvalid & ~axi_lite_rvalid;

   assign axi_lite_awready = wr_go;
   assign axi_lite_wready  = wr_go;
   assign axi_lite_arready = rd_go;

   logic [3:0] wa;
   logic [3:0] ra;
   logic       wr_top0;
   logic       rd_top0;
   assign wa      = axi_lite_awaddr[3:0];
   assign ra      = axi_lite_araddr[3:0];
   assign wr_top0 = (axi_lite_awaddr[31:4] == 28'h0);
   assign rd_top0 = (axi_lite_araddr[31:4] == 28'h0);

   logic wr_hit;
   logic wr_tx;
   logic wr_ovc;
   assign wr_hit = wr_top0
                 & ((wa == ADDR_RX) | (wa == ADDR_TX) | (wa == ADDR_ST));
   assign wr_tx  = wr_go & wr_top0 & (wa == ADDR_TX)
                 & axi_lite_wstrb[0];
   assign wr_ovc = wr_go & wr_top0 & (wa == ADDR_ST)
                 & axi_lite_wstrb[0] & axi_lite_wdata[3];

   logic rd_is_rx;
   logic rd_is_st;
   logic rd_rx;
   assign rd_is_rx = rd_top0 & (ra == ADDR_RX);
   assign rd_is_st = rd_top0 & (ra == ADDR_ST);
   assign rd_rx    = rd_go & rd_is_rx;

   logic [31:0] rd_val;
   always_comb begin
      rd_val = 32'h0;
      unique case (1'b1)
         rd_is_rx: rd_val = {24'h0, rx_data};
         rd_is_st: rd_val = {28'h0, status};
         default: ;
      endcase
   end

   logic unused_bits;
   assign unused_bits = ^{axi_lite_wdata[31:8], axi_lite_wdata[2:0],
                          axi_lite_wdata[7:4], axi_lite_wstrb[3:1]};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         axi_lite_bvalid <= 1'b0;
         axi_lite_bresp  <= 2'b00;
         axi_lite_rvalid <= 1'b0;
         axi_lite_rdata  <= 32'h0;
         rx_shift        <= 7'h0;
         rx_data         <= 8'h0;
         rx_valid        <= 1'b0;
         overrun         <= 1'b0;
         tx_shift        <= 8'h0;
         tx_buf          <= 8'h0;
         tx_full         <= 1'b0;
         bit_cnt         <= 3'd0;
         miso            <= 1'b0;
      end else begin
         if (wr_go) begin
            axi_lite_bvalid <= 1'b1;
            axi_lite_bresp  <= wr_hit ? 2'b00 : 2'b10;
         end else if (axi_lite_bready) begin
            axi_lite_bvalid <= 1'b0;
         end
         if (rd_go) begin
            axi_lite_rvalid <= 1'b1;
            axi_lite_rdata  <= rd_val;
         end else if (axi_lite_rready) begin
            axi_lite_rvalid <= 1'b0;
         end
         if (rd_rx) rx_valid <= 1'b0;
         if (wr_ovc) overrun <= 1'b0;
         if (cs_fall) begin
            bit_cnt  <= 3'd0;
            tx_shift <= load_byte;
            tx_full  <= 1'b0;
            miso     <= load_byte[7];
         end else if (cs_rise) begin
            bit_cnt <= 3'd0;
            miso    <= 1'b0;
         end else if (cs_act && sclk_rise) begin
            rx_shift <= rx_byte[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               rx_data  <= rx_byte;
               rx_valid <= 1'b1;
               // A read clearing the old byte this cycle is not an overrun
               if (rx_valid && !rd_rx) overrun <= 1'b1;
               tx_shift <= load_byte;
               tx_full  <= 1'b0;
            end
         end else if (cs_act && sclk_fall) begin
            if (bit_cnt == 3'd0) begin
               miso <= tx_shift[7];
            end else begin
               miso     <= tx_shift[6];
               tx_shift <= {tx_shift[6:0], 1'b0};
            end
         end
         // CPU write wins over a same-cycle reload, which used old state
         if (wr_tx) begin
            tx_buf  <= axi_lite_wdata[7:0];
            tx_full <= 1'b1;
         end
      end
   end

   assign spi_miso = miso;

endmodule

// File: tb/tb_axi_lite_spi_slave.sv
// Scoreboard bench for axi_lite_spi_slave: random SPI/AXI traffic
// checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_axi_lite_spi_slave;

   localparam int H = 256;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        spi_clk = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready = 1'b1;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;

   always #5 clk = ~clk;

   axi_lite_spi_slave #(.SYNC_STAGES(2)) dut (
      .clk(clk), .resetn(resetn),
      .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .axi_lite_araddr(araddr), .axi_lite_arvalid(arvalid),
      .axi_lite_arready(arready), .axi_lite_rdata(rdata),
      .axi_lite_rvalid(rvalid), .axi_lite_rready(rready),
      .axi_lite_awaddr(awaddr), .axi_lite_awvalid(awvalid),
      .axi_lite_awready(awready), .axi_lite_wdata(wdata),
      .axi_lite_wstrb(wstrb), .axi_lite_wvalid(wvalid),
      .axi_lite_wready(wready), .axi_lite_bresp(bresp),
      .axi_lite_bvalid(bvalid), .axi_lite_bready(bready)
   );

   int n_pass = 0;
   int n_chk  = 0;

   logic [31:0] exp_r[$];
   logic [1:0]  exp_b[$];
   logic [7:0]  exp_m[$];
   logic [7:0]  act_m[$];

   // Reference model state
   bit       m_rxv = 0;
   bit       m_ovr = 0;
   bit       m_txf = 0;
   bit       m_busy = 0;
   logic [7:0] m_rxd = '0;
   logic [7:0] m_buf = '0;
   logic [7:0] m_next = '0;

   function automatic void chk(string name, logic [31:0] act,
                               logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endfunction

   function automatic void tmo(string name);
      n_chk++;
      $display("FAIL %s: got timeout want handshake", name);
   endfunction

   always @(negedge clk) begin
      if (rvalid && rready) begin
         if (exp_r.size() == 0) tmo("r_unexpected");
         else chk("rdata", rdata, exp_r.pop_front());
      end
      if (bvalid && bready) begin
         if (exp_b.size() == 0) tmo("b_unexpected");
         else chk("bresp", 32'(bresp), 32'(exp_b.pop_front()));
      end
      while (act_m.size() > 0) begin
         if (exp_m.size() == 0) begin
            tmo("miso_unexpected");
            void'(act_m.pop_front());
         end else begin
            chk("miso_byte", 32'(act_m.pop_front()),
                32'(exp_m.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_start(input logic [31:0] a);
      logic [31:0] e;
      int i;
      tick();
      e = '0;
      if (a[31:4] == 28'h0) begin
         if (a[3:0] == 4'h0) begin
            e = {24'h0, m_rxd};
            m_rxv = 0;
         end else if (a[3:0] == 4'h8) begin
            e = {28'h0, m_ovr, m_txf, m_rxv, m_busy};
         end
      end
      exp_r.push_back(e);
      araddr = a;
      arvalid = 1'b1;
      for (i = 0; i < 50; i++) begin
         @(negedge clk);
         if (arready) break;
      end
      if (i == 50) tmo("ar_accept");
      tick();
      arvalid = 1'b0;
   endtask

   task automatic rd_drain();
      int i;
      for (i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!rvalid) break;
      end
      if (i == 50) tmo("r_drain");
   endtask

   task automatic rd(input logic [31:0] a);
      rd_start(a);
      rd_drain();
   endtask

   task automatic wr_start(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      bit hit;
      tick();
      hit = (a[31:4] == 28'h0)
          && (a[3:0] == 4'h0 || a[3:0] == 4'h4 || a[3:0] == 4'h8);
      exp_b.push_back(hit ? 2'b00 : 2'b10);
      if (hit && a[3:0] == 4'h4 && s[0]) begin
         m_buf = d[7:0];
         m_txf = 1;
      end
      if (hit && a[3:0] == 4'h8 && s[0] && d[3]) m_ovr = 0;
      awaddr = a;
      wdata = d;
      wstrb = s;
      awvalid = 1'b1;
      wvalid = 1'b1;
   endtask

   task automatic wr_accept();
      int i;
      for (i = 0; i < 50; i++) begin
         @(negedge clk);
         if (awready && wready) break;
      end
      if (i == 50) tmo("aw_accept");
      tick();
      awvalid = 1'b0;
      wvalid = 1'b0;
   endtask

   task automatic wr_drain();
      int i;
      for (i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!bvalid) break;
      end
      if (i == 50) tmo("b_drain");
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
      wr_start(a, d, s);
      wr_accept();
      wr_drain();
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      m_next = m_txf ? m_buf : 8'h00;
      m_txf = 0;
      m_busy = 1;
      #H;
   endtask

   task automatic cs_high();
      #H;
      spi_cs_n = 1'b1;
      m_busy = 0;
      #H;
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      logic [7:0] got;
      got = '0;
      for (int i = 0; i < n; i++) begin
         spi_mosi = b[7-i];
         #H;
         spi_clk = 1'b1;
         got = {got[6:0], spi_miso};
         #H;
         spi_clk = 1'b0;
      end
      if (n == 8) begin
         exp_m.push_back(m_next);
         act_m.push_back(got);
         if (m_rxv) m_ovr = 1;
         m_rxd = b;
         m_rxv = 1;
         m_next = m_txf ? m_buf : 8'h00;
         m_txf = 0;
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int nb;
      repeat (10) @(posedge clk);
      #1;
      chk("reset_out",
          {spi_miso, arready, rvalid, rdata, awready, wready,
           bvalid, bresp}, '0);
      resetn = 1'b1;
      rd(32'h8);

      // receive with STATUS during frame
      cs_low();
      send_bits(8'h10, 8);
      rd(32'h8);
      cs_high();
      rd(32'h0);
      rd(32'h8);

      // full duplex
      wr(32'h4, 32'hA5, 4'h1);
      cs_low();
      send_bits(8'h3C, 8);
      cs_high();
      rd(32'h0);
      rd(32'h8);

      // underrun and overrun
      cs_low();
      send_bits(8'h01, 8);
      send_bits(8'h02, 8);
      cs_high();
      rd(32'h0);
      rd(32'h8);
      wr(32'h8, 32'h8, 4'h1);
      rd(32'h8);

      // abort mid-byte
      cs_low();
      send_bits(8'hB7, 5);
      cs_high();
      chk("abort_miso", 32'(spi_miso), 32'h0);
      rd(32'h8);
      cs_low();
      send_bits(8'h81, 8);
      cs_high();
      rd(32'h0);

      // bvalid held while bready low
      bready = 1'b0;
      wr_start(32'h10, 32'h77, 4'hF);
      wr_accept();
      wr_start(32'h4, 32'h5A, 4'h1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("b_hold", 32'(bvalid), 32'h1);
         chk("aw_block", 32'(awready), 32'h0);
      end
      tick();
      bready = 1'b1;
      wr_accept();
      wr_drain();

      // rvalid/rdata held while rready low
      rready = 1'b0;
      rd_start(32'h8);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("r_hold_v", 32'(rvalid), 32'h1);
         chk("r_hold_d", rdata, exp_r[0]);
      end
      tick();
      rready = 1'b1;
      rd_drain();

      // randomized traffic
      for (int it = 0; it < 8; it++) begin
         if ($urandom_range(1, 0) == 1)
            wr(32'h4, $urandom, 4'($urandom_range(15, 0)));
         if ($urandom_range(3, 0) == 0)
            wr(32'hC, $urandom, 4'hF);
         cs_low();
         nb = $urandom_range(3, 1);
         for (int k = 0; k < nb; k++)
            send_bits(8'($urandom_range(255, 0)), 8);
         cs_high();
         a = 32'($urandom_range(3, 0)) << 2;
         rd(a);
         if ($urandom_range(1, 0) == 1) rd(32'h0);
         rd(32'h8);
         if ($urandom_range(1, 0) == 1)
            wr(32'h8, $urandom, 4'($urandom_range(15, 0)));
      end

      repeat (5) @(negedge clk);
      chk("r_left", 32'(exp_r.size()), 32'h0);
      chk("b_left", 32'(exp_b.size()), 32'h0);
      chk("m_left", 32'(exp_m.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/axi_lite_spi_slave.md
# axi_lite_spi_slave

SPI slave (mode 0, 8-bit frames, MSB first) with an AXI4-Lite register interface, forming the far end of the link driven by `axi_lite_spi_master`. Receives bytes on `spi_mosi`, returns CPU-supplied bytes on `spi_miso`, and exposes RX/TX/status registers to a local processor. SPI pins are oversampled in the `clk` domain; no second clock is used.

## Interface
- `SYNC_STAGES`, 2, synchronizer flops on `spi_clk`, `spi_cs_n`, `spi_mosi`; min 2
- `clk`  in  1  system clock; single clock domain
- `resetn`  in  1  reset, synchronous, active-low
- `spi_clk`  in  1  SPI clock from master, idle low
- `spi_cs_n`  in  1  chip select, active low
- `spi_mosi`  in  1  serial data from master
- `spi_miso`  out  1  serial data to master; driven 0 when `spi_cs_n`=1
- `axi_lite_araddr`  in  32;  `axi_lite_arvalid`  in  1;  `axi_lite_arready`  out  1
- `axi_lite_rdata`  out  32;  `axi_lite_rvalid`  out  1;  `axi_lite_rready`  in  1
- `axi_lite_awaddr`  in  32;  `axi_lite_awvalid`  in  1;  `axi_lite_awready`  out  1
- `axi_lite_wdata`  in  32;  `axi_lite_wstrb`  in  4;  `axi_lite_wvalid`  in  1;  `axi_lite_wready`  out  1
- `axi_lite_bresp`  out  2;  `axi_lite_bvalid`  out  1;  `axi_lite_bready`  in  1

## Operation
- Register map (decode `addr[3:0]`, word aligned):
  - 0x0 RXDATA (RO): `{24'h0, rx_data}`. Read clears `rx_valid`.
  - 0x4 TXDATA (WO, reads 0): write with `wstrb[0]`=1 loads `tx_buf <= wdata[7:0]`, sets `tx_full`; overwrites if already full. `wstrb[0]`=0: no effect, OKAY.
  - 0x8 STATUS: `{28'h0, overrun, tx_full, rx_valid, busy}`; write with `wdata[3]`=1 and `wstrb[0]`=1 clears `overrun`.
  - Other addresses: read 0; write ignored, `bresp`=2'b10 (SLVERR); mapped writes 2'b00.
- Write channel: `awready`=`wready`=1 for one cycle when `awvalid`&`wvalid`&!`bvalid`; register updates that cycle; `bvalid` next cycle, held until `bready`. AW without W (or vice versa) waits.
- Read channel: `arready`=1 for one cycle when `arvalid`&!`rvalid`; `rdata` registered, `rvalid` next cycle, held until `rready`. RXDATA side effect at address acceptance.
- SPI front end: `SYNC_STAGES` flops per pin, then one edge-detect register. `busy` = synced `cs_n`==0.
- CS fall: `bit_cnt`<=0; `tx_shift`<=`tx_full`?`tx_buf`:8'h00; `tx_full`<=0; `spi_miso`<=that byte[7].
- Rising `spi_clk` (cs active): `rx_shift`<={rx_shift[6:0],mosi}; `bit_cnt`+1 (3-bit, wraps). When `bit_cnt`==7: `rx_data`<=completed byte, `rx_valid`<=1, `overrun`<=1 if `rx_valid` already 1 (new byte overwrites); reload `tx_shift` from `tx_buf`/8'h00 as at CS fall, clear `tx_full`.
- Falling `spi_clk` (cs active): if `bit_cnt`==0 `spi_miso`<=tx_shift[7]; else `spi_miso`<=tx_shift[6], `tx_shift`<<=1.
- CS rise mid-byte: partial byte discarded, `bit_cnt`<=0, no `rx_valid`; `spi_miso`<=0.

## Timing
- Reset (`resetn`=0 at `clk` edge): all outputs 0 (`spi_miso`, `arready`, `rvalid`, `rdata`, `awready`, `wready`, `bvalid`, `bresp`); `rx_valid`,`tx_full`,`overrun`,`bit_cnt`, shift regs, `tx_buf`,`rx_data` cleared. Reset mid-frame aborts it; slave resumes at next CS fall.
- Pin-to-action latency: `SYNC_STAGES`+1 clk (3 default). `spi_clk` high and low each ≥ `SYNC_STAGES`+2 clk; CS fall to first rising edge ≥ same.
- Byte complete to `rx_valid` visible in STATUS read: accepted on the next `arready`.
- Simultaneous RXDATA read and byte completion: read returns old byte; new byte lands, `rx_valid`=1, no overrun.
- Simultaneous TXDATA write and reload: reload uses pre-write state (sends 8'h00 if empty); written byte stays in `tx_buf`, `tx_full`=1.

## Test plan
- Reset: hold `resetn`=0 10 clk -> all outputs 0; STATUS reads 0x0.
- Receive: CS low, master sends 0x10 (SPI clk period 512 ns) -> STATUS=0x3 during frame, RXDATA read returns 0x10, then STATUS `rx_valid`=0.
- Full duplex: write TXDATA=0xA5 (bresp 00), master sends 0x3C -> master samples 0xA5 on `spi_miso`, RXDATA=0x3C, `tx_full`=0.
- Underrun/overrun: no TX write, master sends 0x01,0x02 without CPU read -> `spi_miso` bytes 0x00,0x00; RXDATA=0x02, `overrun`=1; write STATUS 0x8 -> `overrun`=0.
- Abort: CS high after 5 bits -> `rx_valid` stays 0, `spi_miso`=0; next full frame 0x81 received correctly.
- AXI corners: write to 0x10 -> bresp 2'b10; hold `bready`=0 5 clk -> `bvalid` held, second write not accepted; `rready`=0 holds `rvalid`/`rdata` stable.
